// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state type, data width default and checksum clear value
package fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int CHK_CLR = 0;
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;
endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: 2-entry in-order buffer with push/pop, occupancy count and head entry
module fifo_skid2 #(
  parameter int W = 9
) (
  input  logic         clka,
  input  logic         rstna,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: packet source to async-FIFO write port; FIFO_PKT_WRITER_CHKSUM_EN appends an XOR trailer byte
module fifo_pkt_writer import fifo_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNTW = 16
) (
  input  logic             clka,
  input  logic             rstna,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  input  logic             fulla,
  output logic             wreqa,
  output logic [DSIZE-1:0] wdata,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic             busy
);
  state_t state, state_nxt;
  logic [1:0] count;
  logic [DSIZE:0] head, din;
  logic acc, push;
  assign s_ready = (count != 2'd2) && (state != TRAILER);
  assign acc = s_valid && s_ready;
  assign wreqa = (count != 2'd0) && !fulla;
  assign wdata = head[DSIZE-1:0];
  assign busy = (state != IDLE) || (count != 2'd0);
`ifdef FIFO_PKT_WRITER_CHKSUM_EN
  logic [DSIZE-1:0] chk;
  logic push_trl;
  assign push_trl = (state == TRAILER) && (count != 2'd2);
  assign push = acc || push_trl;
  assign din = push_trl ? {1'b1, chk} : {1'b0, s_data};
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) chk <= DSIZE'(CHK_CLR);
    else if (push_trl) chk <= DSIZE'(CHK_CLR);
    else if (acc) chk <= chk ^ s_data;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == TRAILER) ? (push_trl ? IDLE : TRAILER) :
                !acc ? state : s_last ? TRAILER : PAYLOAD;
  end
`else
  assign push = acc;
  assign din = {s_last, s_data};
  always_comb begin
    state_nxt = state;
    state_nxt = !acc ? state : s_last ? IDLE : PAYLOAD;
  end
`endif
  // head[DSIZE] flags the byte that completes a packet
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      state <= IDLE;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (wreqa && head[DSIZE]) pkt_cnt <= pkt_cnt + CNTW'(1);
    end
  end
  fifo_skid2 #(.W(DSIZE + 1)) u_buf (
    .clka (clka),
    .rstna(rstna),
    .push (push),
    .pop  (wreqa),
    .din  (din),
    .count(count),
    .head (head)
  );
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb_fifo_pkt_writer: randomized and directed checks against a queue-based packet model
module tb_fifo_pkt_writer;
  logic clka = 1'b0, rstna = 1'b0, s_valid = 1'b0, s_last = 1'b0, fulla = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, wreqa, busy;
  logic [7:0] wdata;
  logic [3:0] pkt_cnt;
  logic [8:0] q[$];
  logic [7:0] sum;
  logic [3:0] ecnt;
  bit trl, inpkt;
  int n_cmp = 0, n_bad = 0;
  fifo_pkt_writer #(.DSIZE(8), .CNTW(4)) dut (
    .clka(clka), .rstna(rstna), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fulla(fulla), .wreqa(wreqa), .wdata(wdata), .pkt_cnt(pkt_cnt), .busy(busy)
  );
  always #5 clka = ~clka;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic f, output bit acc);
    int occ;
    bit er;
    s_valid = v; s_data = d; s_last = l; fulla = f;
    #1;
    occ = q.size();
    er = occ != 2 && !trl;
    chk("s_ready", 16'(s_ready), 16'(er));
    chk("wreqa", 16'(wreqa), 16'(occ != 0 && !f));
    chk("busy", 16'(busy), 16'(occ != 0 || inpkt || trl));
    chk("pkt_cnt", 16'(pkt_cnt), 16'(ecnt));
    if (occ != 0) chk("wdata", 16'(wdata), 16'(q[0][7:0]));
    acc = v && er;
    if (occ != 0 && !f) begin
      if (q[0][8]) ecnt++;
      void'(q.pop_front());
    end
    if (trl && occ != 2) begin
      q.push_back({1'b1, sum});
      sum = 8'h00;
      trl = 0;
    end
    if (acc) begin
`ifdef FIFO_PKT_WRITER_CHKSUM_EN
      sum ^= d;
      q.push_back({1'b0, d});
      trl = l;
`else
      q.push_back({l, d});
`endif
      inpkt = !l;
    end
    @(posedge clka);
    @(negedge clka);
  endtask
  task automatic idle(input int n);
    bit a;
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, a);
  endtask
  task automatic do_reset();
    rstna = 1'b0; s_valid = 1'b0; s_last = 1'b0; fulla = 1'b0;
    #1;
    chk("rst_s_ready", 16'(s_ready), 16'd1);
    chk("rst_wreqa", 16'(wreqa), 16'd0);
    chk("rst_wdata", 16'(wdata), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_pkt_cnt", 16'(pkt_cnt), 16'd0);
    q.delete(); sum = 8'h00; trl = 0; inpkt = 0; ecnt = 4'd0;
    @(posedge clka);
    @(negedge clka);
    rstna = 1'b1;
  endtask
  task automatic send_beat(input logic [7:0] d, input logic l, input bit rnd);
    bit a = 0;
    for (int t = 0; t < 40 && !a; t++)
      cyc(rnd ? ($urandom_range(0, 4) != 0) : 1'b1, d, l, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, a);
    if (!a) begin
      n_bad++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask
  task automatic send_pkt(input int len, input bit rnd);
    for (int i = 0; i < len; i++) send_beat(8'($urandom), i == len - 1, rnd);
  endtask
  initial begin
    logic [7:0] pat [6];
    bit a;
    int i;
    @(negedge clka);
    do_reset();
    idle(3);
    send_beat(8'h11, 1'b0, 0);
    send_beat(8'h22, 1'b0, 0);
    send_beat(8'h33, 1'b1, 0);
    idle(4);
    chk("pkt3_cnt", 16'(pkt_cnt), 16'd1);
    chk("pkt3_busy", 16'(busy), 16'd0);
    for (int k = 0; k < 6; k++) pat[k] = 8'($urandom);
    i = 0;
    for (int k = 0; k < 20 && i < 6; k++) begin
      cyc(1'b1, pat[i], i == 5, k < 5, a);
      if (a) i++;
    end
    chk("stall_sent", 16'(i), 16'd6);
    idle(4);
    chk("stall_cnt", 16'(pkt_cnt), 16'd2);
    send_beat(8'hA5, 1'b1, 0);
    idle(4);
    chk("single_cnt", 16'(pkt_cnt), 16'd3);
    do_reset();
    for (int p = 0; p < 16; p++) send_pkt($urandom_range(1, 5), 1);
    idle(4);
    chk("wrap_cnt", 16'(pkt_cnt), 16'd0);
    send_beat(8'h5A, 1'b0, 0);
    send_beat(8'hC3, 1'b0, 0);
    do_reset();
    chk("post_rst_wreqa", 16'(wreqa), 16'd0);
    send_pkt(3, 0);
    idle(4);
    chk("post_rst_cnt", 16'(pkt_cnt), 16'd1);
    for (int p = 0; p < 6; p++) send_pkt($urandom_range(1, 4), 0);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_writer.md
FIFO_PKT_WRITER -- requirements
Module: fifo_pkt_writer

Interface
REQ-001 Parameter DSIZE, default 8: payload/FIFO data width in bits.
REQ-002 Parameter CNTW, default 16: packet counter width in bits.
REQ-003 clka  input  1  write-domain clock; all logic is on its rising edge.
REQ-004 rstna  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  source beat valid.
REQ-006 s_ready  output  1  block accepts a beat; a transfer occurs when s_valid and s_ready are both 1.
REQ-007 s_data  input  DSIZE  source payload byte.
REQ-008 s_last  input  1  marks the final payload beat of a packet.
REQ-009 fulla  input  1  full flag from the downstream async FIFO write port.
REQ-010 wreqa  output  1  FIFO write request.
REQ-011 wdata  output  DSIZE  FIFO write data.
REQ-012 pkt_cnt  output  CNTW  number of complete packets written to the FIFO.
REQ-013 busy  output  1  packet in progress or data still buffered.

Function
REQ-014 Internal 2-entry in-order buffer; occupancy count is 0, 1 or 2.
REQ-015 wreqa = (count != 0) & ~fulla, combinational; wdata = head entry; the entry is popped on every clka edge with wreqa = 1.
REQ-016 s_ready = (count != 2) & (state != TRAILER), decoded from registers only; no combinational path from fulla or s_valid to s_ready.
REQ-017 Push and pop in the same cycle leave count unchanged; order is preserved.
REQ-018 fulla = 1: wreqa = 0, head entry and wdata held stable; no data lost or duplicated.
REQ-019 FSM states IDLE, PAYLOAD, TRAILER; encoding free.
REQ-020 IDLE -> PAYLOAD on an accepted beat with s_last = 0; IDLE on an accepted beat with s_last = 1 -> TRAILER (CHKSUM_EN) or stay IDLE (no CHKSUM_EN).
REQ-021 PAYLOAD: accepted beat with s_last = 1 -> TRAILER (CHKSUM_EN) or IDLE (no CHKSUM_EN); otherwise stay.
REQ-022 TRAILER: pushes the checksum byte in the first cycle with count != 2, then -> IDLE the next cycle.
REQ-023 Checksum = bitwise XOR of all payload bytes of the current packet, cleared to 0 when a packet completes; trailer byte contains only payload bytes of its own packet.
REQ-024 pkt_cnt increments by 1 on the FIFO write of a packet's final byte (trailer if CHKSUM_EN, else the s_last payload byte); wraps from 2^CNTW-1 to 0.
REQ-025 busy = (state != IDLE) | (count != 0).
REQ-026 Latency: an accepted beat into an empty buffer with fulla = 0 appears on wreqa/wdata in the next cycle.
REQ-027 Sustained throughput one beat per cycle while fulla = 0 (no CHKSUM_EN); one extra cycle per packet with CHKSUM_EN.

Reset
REQ-028 rstna low: count = 0, state = IDLE, checksum = 0, pkt_cnt = 0, buffer entries = 0.
REQ-029 Reset outputs: wreqa = 0, wdata = 0, s_ready = 1, busy = 0; pkt_cnt = 0.
REQ-030 Reset asserted mid-packet discards buffered data and the partial packet; no FIFO write in the first cycle after release.

Configuration
REQ-031 Macro FIFO_PKT_WRITER_CHKSUM_EN: defined -> TRAILER state and checksum appended after every packet; undefined -> TRAILER and checksum logic absent, pure pass-through with packet counting.

Structure
REQ-032 Shared package fifo_pkg holds the FSM state typedef, DSIZE default and the checksum-clear value.
REQ-033 Sub-module fifo_skid2 implements the 2-entry buffer (push, pop, count, head); the FSM, checksum and counter stay in the top.

Verification
REQ-034 Reset release, idle inputs -> wreqa = 0, s_ready = 1, pkt_cnt = 0, busy = 0.
REQ-035 Packet 0x11,0x22,0x33 (last), fulla = 0, CHKSUM_EN -> FIFO writes 0x11,0x22,0x33,0x00 on consecutive cycles; pkt_cnt = 1.
REQ-036 Same packet without CHKSUM_EN -> writes 0x11,0x22,0x33 only; pkt_cnt = 1 after 0x33 written.
REQ-037 fulla held 1 for 5 cycles during continuous s_valid -> s_ready drops after 2 accepts, wdata stable, no write; on release all bytes written in order.
REQ-038 Single-beat packet 0xA5 with s_last = 1, CHKSUM_EN -> writes 0xA5,0xA5; pkt_cnt = 1.
REQ-039 pkt_cnt preset-near-wrap via 2^CNTW packets (CNTW = 4, 16 packets) -> pkt_cnt returns to 0; rstna pulse mid-packet -> buffer flushed, next packet checksum correct.
